// File: rtl/i2c_bus_filter_mon.sv
// I2C bus observer: 2-flop sync, tick-sampled majority glitch filter, START/STOP detection,
// bus-free and SCL-stuck timers, SCL high/low gauge. Observes only; never drives the pads.
module i2c_bus_filter_mon #(
  parameter int FILT_DEPTH = 5,
  parameter int PRESC_W    = 14,
  parameter int CNT_W      = 32,
  parameter int TMO_W      = 20
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               scl_raw,
  input  logic               sda_raw,
  input  logic [PRESC_W-1:0] presc,
  input  logic               gauge_en,
  input  logic [TMO_W-1:0]   tbuf_cnt,
  input  logic [TMO_W-1:0]   stuck_cnt,
  output logic               scl_f,
  output logic               sda_f,
  output logic               scl_rise,
  output logic               scl_fall,
  output logic               sta_det,
  output logic               rsta_det,
  output logic               sto_det,
  output logic               busy,
  output logic               bus_free,
  output logic               scl_stuck,
  output logic [CNT_W-1:0]   thigh,
  output logic [CNT_W-1:0]   tlow
);

  logic                  scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d;
  logic                  sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d;
  logic [PRESC_W-1:0]    presc_cnt_q, presc_cnt_d;
  logic [FILT_DEPTH-1:0] scl_sh_q, scl_sh_d, sda_sh_q, sda_sh_d;
  logic                  s_scl_q, s_scl_d, s_sda_q, s_sda_d;
  logic                  d_scl_q, d_scl_d, d_sda_q, d_sda_d;
  logic                  busy_q, busy_d;
  logic [TMO_W-1:0]      free_cnt_q, free_cnt_d;
  logic [TMO_W-1:0]      low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0]      gauge_cnt_q, gauge_cnt_d;
  logic [CNT_W-1:0]      thigh_q, thigh_d, tlow_q, tlow_d;

  logic tick, rise, fall, start, stop, free_w, stuck_w;

  function automatic logic majority(input logic [FILT_DEPTH-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < FILT_DEPTH; i++) ones += int'(v[i]);
    return ones > (FILT_DEPTH / 2);
  endfunction

  // Bus conditions compare the filtered line (s_*) against its one-clk-delayed copy (d_*).
  assign tick    = (presc_cnt_q == '0);
  assign rise    = ~d_scl_q & s_scl_q;
  assign fall    = d_scl_q & ~s_scl_q;
  assign start   = d_scl_q & s_scl_q & d_sda_q & ~s_sda_q;
  assign stop    = d_scl_q & s_scl_q & ~d_sda_q & s_sda_q;
  assign free_w  = (free_cnt_q == tbuf_cnt) & s_scl_q & s_sda_q & ~start;
  assign stuck_w = (stuck_cnt != '0) & (low_cnt_q == stuck_cnt);

  always_comb begin
    scl_meta_d  = scl_raw;
    sda_meta_d  = sda_raw;
    scl_sync_d  = scl_meta_q;
    sda_sync_d  = sda_meta_q;
    presc_cnt_d = tick ? presc : presc_cnt_q - PRESC_W'(1);

    scl_sh_d = scl_sh_q;
    sda_sh_d = sda_sh_q;
    if (tick) begin
      scl_sh_d = {scl_sh_q[FILT_DEPTH-2:0], scl_sync_q};
      sda_sh_d = {sda_sh_q[FILT_DEPTH-2:0], sda_sync_q};
    end
    s_scl_d = majority(scl_sh_q);
    s_sda_d = majority(sda_sh_q);
    d_scl_d = s_scl_q;
    d_sda_d = s_sda_q;

    // START wins over any same-cycle release of the bus.
    busy_d = busy_q;
    if (start) busy_d = 1'b1;
    else if (stop | free_w | stuck_w) busy_d = 1'b0;

    free_cnt_d = free_cnt_q;
    if (~s_scl_q | ~s_sda_q | start) free_cnt_d = '0;
    else if (~busy_q && (free_cnt_q < tbuf_cnt)) free_cnt_d = free_cnt_q + TMO_W'(1);

    low_cnt_d = low_cnt_q;
    if (rise) low_cnt_d = '0;
    else if (~s_scl_q && (low_cnt_q < stuck_cnt)) low_cnt_d = low_cnt_q + TMO_W'(1);

    gauge_cnt_d = gauge_cnt_q;
    thigh_d     = thigh_q;
    tlow_d      = tlow_q;
    if (gauge_en) begin
      if (rise | fall) gauge_cnt_d = '0;
      else if (busy_q && (gauge_cnt_q != '1)) gauge_cnt_d = gauge_cnt_q + CNT_W'(1);
      if (rise) tlow_d = gauge_cnt_q;
      if (fall) thigh_d = gauge_cnt_q;
    end
  end

  // Everything resets to the idle-high bus so a mid-transfer reset produces no bus events.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_meta_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      presc_cnt_q <= '0;
      scl_sh_q    <= '1;
      sda_sh_q    <= '1;
      s_scl_q     <= 1'b1;
      s_sda_q     <= 1'b1;
      d_scl_q     <= 1'b1;
      d_sda_q     <= 1'b1;
      busy_q      <= 1'b0;
      free_cnt_q  <= '0;
      low_cnt_q   <= '0;
      gauge_cnt_q <= '0;
      thigh_q     <= '0;
      tlow_q      <= '0;
    end else begin
      scl_meta_q  <= scl_meta_d;
      sda_meta_q  <= sda_meta_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      presc_cnt_q <= presc_cnt_d;
      scl_sh_q    <= scl_sh_d;
      sda_sh_q    <= sda_sh_d;
      s_scl_q     <= s_scl_d;
      s_sda_q     <= s_sda_d;
      d_scl_q     <= d_scl_d;
      d_sda_q     <= d_sda_d;
      busy_q      <= busy_d;
      free_cnt_q  <= free_cnt_d;
      low_cnt_q   <= low_cnt_d;
      gauge_cnt_q <= gauge_cnt_d;
      thigh_q     <= thigh_d;
      tlow_q      <= tlow_d;
    end
  end

  assign scl_f     = d_scl_q;
  assign sda_f     = d_sda_q;
  assign scl_rise  = rise;
  assign scl_fall  = fall;
  assign sta_det   = start;
  assign rsta_det  = start & busy_q;
  assign sto_det   = stop;
  assign busy      = busy_q;
  assign bus_free  = free_w;
  assign scl_stuck = stuck_w;
  assign thigh     = thigh_q;
  assign tlow      = tlow_q;

endmodule

// File: tb/tb_i2c_bus_filter_mon.sv
// Scoreboarded bench for i2c_bus_filter_mon: directed scenarios plus random line activity,
// checked every cycle against a rule-level bus model.
module tb_i2c_bus_filter_mon;
  localparam int D  = 5;
  localparam int PW = 14;
  localparam int CW = 32;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          scl_raw = 1'b1, sda_raw = 1'b1;
  logic [PW-1:0] presc = '0;
  logic          gauge_en = 1'b1;
  logic [TW-1:0] tbuf_cnt = 20'd50, stuck_cnt = 20'd100;
  logic          scl_f, sda_f, scl_rise, scl_fall, sta_det, rsta_det, sto_det;
  logic          busy, bus_free, scl_stuck;
  logic [CW-1:0] thigh, tlow;

  i2c_bus_filter_mon #(.FILT_DEPTH(D), .PRESC_W(PW), .CNT_W(CW), .TMO_W(TW)) dut (
    .clk(clk), .rstn(rstn), .scl_raw(scl_raw), .sda_raw(sda_raw), .presc(presc),
    .gauge_en(gauge_en), .tbuf_cnt(tbuf_cnt), .stuck_cnt(stuck_cnt),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .sta_det(sta_det), .rsta_det(rsta_det), .sto_det(sto_det), .busy(busy),
    .bus_free(bus_free), .scl_stuck(scl_stuck), .thigh(thigh), .tlow(tlow));

  always #5 clk = ~clk;

  typedef struct packed {
    logic scl_f, sda_f, rise, fall, sta, rsta, sto, busy, free, stuck;
    logic [31:0] thigh, tlow;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_err = 0;
  int   n_rise = 0, n_fall = 0, n_sta = 0, n_rsta = 0, n_sto = 0;
  bit   sda_lo_seen = 0;

  // Reference model state: what the bus "looks like" after each clock edge.
  bit      mm_scl, mm_sda, ms_scl, ms_sda;   // synchroniser stages
  bit      win_scl[$], win_sda[$];            // last D tick samples, newest first
  bit      f_scl, f_sda, p_scl, p_sda;        // filtered line and its previous value
  bit      m_busy;
  int      m_idle, m_low, m_cyc, m_next_tick;
  longint  m_gauge, m_thigh, m_tlow;

  function automatic bit more_than_half_ones(input bit w[$]);
    int ones = 0;
    foreach (w[i]) ones += int'(w[i]);
    return ones > D / 2;
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    e.scl_f = p_scl;
    e.sda_f = p_sda;
    e.rise  = f_scl && !p_scl;
    e.fall  = !f_scl && p_scl;
    e.sta   = p_scl && f_scl && p_sda && !f_sda;
    e.sto   = p_scl && f_scl && !p_sda && f_sda;
    e.rsta  = e.sta && m_busy;
    e.busy  = m_busy;
    e.free  = (m_idle == int'(tbuf_cnt)) && f_scl && f_sda && !e.sta;
    e.stuck = (stuck_cnt != 0) && (m_low == int'(stuck_cnt));
    e.thigh = m_thigh[31:0];
    e.tlow  = m_tlow[31:0];
    return e;
  endfunction

  task automatic model_reset();
    mm_scl = 1; mm_sda = 1; ms_scl = 1; ms_sda = 1;
    win_scl.delete(); win_sda.delete();
    for (int i = 0; i < D; i++) begin win_scl.push_back(1'b1); win_sda.push_back(1'b1); end
    f_scl = 1; f_sda = 1; p_scl = 1; p_sda = 1;
    m_busy = 0; m_idle = 0; m_low = 0; m_gauge = 0; m_thigh = 0; m_tlow = 0;
    m_cyc = 0; m_next_tick = 0;
  endtask

  task automatic model_clock();
    exp_t cur;
    bit   nf_scl, nf_sda;
    cur    = model_view();
    nf_scl = more_than_half_ones(win_scl);
    nf_sda = more_than_half_ones(win_sda);
    if (m_cyc == m_next_tick) begin
      win_scl.push_front(ms_scl); void'(win_scl.pop_back());
      win_sda.push_front(ms_sda); void'(win_sda.pop_back());
      m_next_tick = m_cyc + int'(presc) + 1;
    end
    if (!f_scl || !f_sda || cur.sta) m_idle = 0;
    else if (!m_busy && m_idle < int'(tbuf_cnt)) m_idle++;
    if (cur.rise) m_low = 0;
    else if (!f_scl && m_low < int'(stuck_cnt)) m_low++;
    if (gauge_en) begin
      if (cur.rise) m_tlow = m_gauge;
      if (cur.fall) m_thigh = m_gauge;
      if (cur.rise || cur.fall) m_gauge = 0;
      else if (m_busy && m_gauge < 64'hFFFF_FFFF) m_gauge++;
    end
    if (cur.sta) m_busy = 1;
    else if (cur.sto || cur.free || cur.stuck) m_busy = 0;
    p_scl = f_scl; p_sda = f_sda; f_scl = nf_scl; f_sda = nf_sda;
    ms_scl = mm_scl; ms_sda = mm_sda; mm_scl = scl_raw; mm_sda = sda_raw;
    m_cyc++;
  endtask

  // Stimulus side: advance the model at every edge and queue what the DUT must show next.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rstn) model_reset();
      else model_clock();
      exp_q.push_back(model_view());
    end
  end

  // Monitor: compare the DUT against the queued expectation mid-cycle.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {scl_f, sda_f, scl_rise, scl_fall, sta_det, rsta_det, sto_det, busy, bus_free,
             scl_stuck, thigh, tlow};
        n_checks++;
        if (a !== e) begin
          n_err++;
          $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, a, e);
        end
      end
      if (scl_rise) n_rise++;
      if (scl_fall) n_fall++;
      if (sta_det) n_sta++;
      if (rsta_det) n_rsta++;
      if (sto_det) n_sto++;
      if (!sda_f) sda_lo_seen = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic do_reset(input int tb, input int st);
    @(negedge clk);
    #1;
    rstn = 0; tbuf_cnt = TW'(tb); stuck_cnt = TW'(st); scl_raw = 1; sda_raw = 1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  initial begin
    int base_sta, base_sto, base_rsta, base_rise, base_fall;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    check("reset_busy", 32'(busy), 0);
    step(60);
    check("idle_free", 32'(bus_free), 1);

    // START latency with presc=0
    base_rsta = n_rsta;
    sda_raw = 0;
    step(6);
    check("sda_f_before", 32'(sda_f), 1);
    check("sta_pulse", 32'(sta_det), 1);
    check("no_rsta", 32'(rsta_det), 0);
    step(1);
    check("sda_f_after", 32'(sda_f), 0);
    check("sta_one_clk", 32'(sta_det), 0);
    check("busy_set", 32'(busy), 1);

    // glitch rejection with presc=3
    sda_raw = 1; step(20);
    presc = 3; step(20);
    base_sta = n_sta; sda_lo_seen = 0;
    sda_raw = 0; step(4); sda_raw = 1; step(40);
    check("glitch_no_sta", 32'(n_sta - base_sta), 0);
    check("glitch_sda_f", 32'(sda_lo_seen), 0);
    sda_raw = 0; step(16); sda_raw = 1; step(40);
    check("long_pulse_sta", 32'(n_sta - base_sta), 1);

    // SCL gauge
    presc = 0; step(10);
    sda_raw = 0; step(20);
    base_rise = n_rise; base_fall = n_fall;
    for (int i = 0; i < 4; i++) begin
      scl_raw = 0; step(10); scl_raw = 1; step(6);
    end
    step(20);
    check("tlow", tlow, 9);
    check("thigh", thigh, 5);
    check("rise_cnt", 32'(n_rise - base_rise), 4);
    check("fall_cnt", 32'(n_fall - base_fall), 4);

    // STOP then bus-free timing
    base_sto = n_sto;
    sda_raw = 1; step(30);
    check("sto_pulse", 32'(n_sto - base_sto), 1);
    check("busy_clr", 32'(busy), 0);
    check("free_early", 32'(bus_free), 0);
    step(40);
    check("free_late", 32'(bus_free), 1);

    // repeated START
    sda_raw = 0; step(20);
    base_sto = n_sto; base_rsta = n_rsta;
    scl_raw = 0; step(10); sda_raw = 1; step(10); scl_raw = 1; step(15); sda_raw = 0; step(15);
    check("rsta_cnt", 32'(n_rsta - base_rsta), 1);
    check("rsta_no_sto", 32'(n_sto - base_sto), 0);
    check("rsta_busy", 32'(busy), 1);

    // SCL stuck low
    scl_raw = 0; step(100);
    check("stuck_early", 32'(scl_stuck), 0);
    step(10);
    check("stuck_set", 32'(scl_stuck), 1);
    check("stuck_busy", 32'(busy), 0);
    step(90);
    scl_raw = 1; step(6);
    check("stuck_rise", 32'({scl_rise, scl_stuck}), 3);
    step(1);
    check("stuck_clr", 32'(scl_stuck), 0);

    // reset mid-transfer
    sda_raw = 1; step(20); sda_raw = 0; step(10); scl_raw = 0; step(5);
    @(negedge clk);
    #1;
    rstn = 0;
    #1;
    check("rst_flags", 32'({scl_f, sda_f, scl_rise, scl_fall, sta_det, rsta_det, sto_det,
                            busy, bus_free, scl_stuck}), 32'h300);
    check("rst_thigh", thigh, 0);
    check("rst_tlow", tlow, 0);
    scl_raw = 1; sda_raw = 1;
    step(3);
    rstn = 1;
    step(10);

    // random activity, checked by the scoreboard
    for (int it = 0; it < 300; it++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 3) do_reset(int'($urandom_range(1, 60)),
                          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 120)));
      else if (r < 10) begin
        presc = PW'($urandom_range(0, 3));
        gauge_en = 1'($urandom_range(0, 1));
      end else begin
        if (r < 55) scl_raw = ~scl_raw;
        else if (r < 95) sda_raw = ~sda_raw;
        else begin scl_raw = ~scl_raw; sda_raw = ~sda_raw; end
        step(int'($urandom_range(1, 25)));
      end
    end
    step(30);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
